// File: rtl/fifo_sc_pkg.sv
// Shared definitions for the single-clock flag FIFO: address-width helper
// and the accepted REGMODE strings.
package fifo_sc_pkg;

  localparam string REGMODE_REG   = "reg";
  localparam string REGMODE_NOREG = "noreg";

  // Smallest n with 2**n >= value; used to size pointers from DEPTH.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sc_ram.sv
// Simple dual-port storage for the FIFO: one write port, one synchronous
// read port with read enable so the read word holds between reads.
// Contents are never reset.
module fifo_sc_ram #(
  parameter int DEPTH      = 512,
  parameter int DATA_WIDTH = 36,
  parameter int AW         = 9
) (
  input  logic                  wr_clk_i,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port on the same clock.
  always_ff @(posedge wr_clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

endmodule

// File: rtl/fifo_sc_flags.sv
// Single-clock FIFO with registered full/empty and hysteresis almost flags.
// Build option: define FIFO_SC_DATA_CNT_EN to expose the registered
// occupancy on data_cnt_o; otherwise data_cnt_o is tied to zero.
module fifo_sc_flags
  import fifo_sc_pkg::*;
#(
  parameter int    DEPTH      = 512,
  parameter int    DATA_WIDTH = 36,
  parameter string REGMODE    = "reg",
  localparam int   AW         = clog2(DEPTH)
) (
  input  logic                  wr_clk_i,
  input  logic                  rst_i,
  input  logic                  rp_rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [AW:0]           almost_full_th_i,
  input  logic [AW:0]           almost_full_clr_th_i,
  input  logic [AW:0]           almost_empty_th_i,
  input  logic [AW:0]           almost_empty_clr_th_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [AW:0]           data_cnt_o
);

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [AW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [AW:0]           cnt_reg, cnt_next;
  logic                  full_reg, full_next;
  logic                  empty_reg, empty_next;
  logic                  afull_reg, afull_next;
  logic                  aempty_reg, aempty_next;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // A flush blocks both ports; otherwise the registered flags gate them,
  // which also gives read-only at full and write-only at empty.
  assign wr_acc = wr_en_i & ~full_reg  & ~rp_rst_i;
  assign rd_acc = rd_en_i & ~empty_reg & ~rp_rst_i;

  // Next pointers, occupancy and flags, all derived from next occupancy.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    cnt_next    = cnt_reg;
    afull_next  = afull_reg;
    aempty_next = aempty_reg;
    if (wr_acc) begin
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   cnt_next = cnt_reg + 1'b1;
      2'b01:   cnt_next = cnt_reg - 1'b1;
      default: cnt_next = cnt_reg;
    endcase
    if (rp_rst_i) begin
      rd_ptr_next = wr_ptr_reg;
      cnt_next    = '0;
    end
    full_next  = (cnt_next == CNT_FULL);
    empty_next = (cnt_next == '0);
    // Clear is evaluated first so that the set condition wins on overlap.
    if (cnt_next <= almost_full_clr_th_i) afull_next = 1'b0;
    if (cnt_next >= almost_full_th_i)     afull_next = 1'b1;
    if (cnt_next >= almost_empty_clr_th_i) aempty_next = 1'b0;
    if (cnt_next <= almost_empty_th_i)     aempty_next = 1'b1;
    if (rp_rst_i) begin
      afull_next  = 1'b0;
      aempty_next = 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge wr_clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      afull_reg  <= 1'b0;
      aempty_reg <= 1'b1;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      cnt_reg    <= cnt_next;
      full_reg   <= full_next;
      empty_reg  <= empty_next;
      afull_reg  <= afull_next;
      aempty_reg <= aempty_next;
    end
  end

  fifo_sc_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_ram (
    .wr_clk_i  (wr_clk_i),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_reg),
    .wr_data_i (wr_data_i),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_reg),
    .rd_data_o (ram_rd_data)
  );

  generate
    if (REGMODE == REGMODE_NOREG) begin : g_noreg
      logic rd_seen_reg;
      // The RAM itself cannot be reset, so mask its output until the
      // first read after reset has loaded a real word.
      always_ff @(posedge wr_clk_i or posedge rst_i) begin
        if (rst_i) begin
          rd_seen_reg <= 1'b0;
        end else if (rd_acc) begin
          rd_seen_reg <= 1'b1;
        end
      end
      assign rd_data_o = rd_seen_reg ? ram_rd_data : '0;
    end else begin : g_reg
      logic                  rd_vld_reg;
      logic [DATA_WIDTH-1:0] dout_reg;
      // Valid pipeline plus output register: adds one edge of latency and
      // only reloads when a read word is arriving from the RAM.
      always_ff @(posedge wr_clk_i or posedge rst_i) begin
        if (rst_i) begin
          rd_vld_reg <= 1'b0;
          dout_reg   <= '0;
        end else begin
          rd_vld_reg <= rd_acc;
          if (rd_vld_reg) begin
            dout_reg <= ram_rd_data;
          end
        end
      end
      assign rd_data_o = dout_reg;
    end
  endgenerate

  assign full_o         = full_reg;
  assign empty_o        = empty_reg;
  assign almost_full_o  = afull_reg;
  assign almost_empty_o = aempty_reg;

`ifdef FIFO_SC_DATA_CNT_EN
  assign data_cnt_o = cnt_reg;
`else
  assign data_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fifo_sc_flags.sv
// Directed bench: instance a is DEPTH=16 with output register, instance b
// is DEPTH=12 without, sharing clock and asynchronous reset.
module tb_fifo_sc_flags;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Instance a: DEPTH 16, REGMODE "reg", afull 8/3, aempty 2/6
  logic        a_rp_rst, a_wr_en, a_rd_en;
  logic [35:0] a_wr_data, a_rd_data;
  logic        a_full, a_empty, a_afull, a_aempty;
  logic [4:0]  a_data_cnt;
  logic [4:0]  a_af_th = 5'd8, a_af_clr = 5'd3, a_ae_th = 5'd2, a_ae_clr = 5'd6;

  // Instance b: DEPTH 12, REGMODE "noreg", afull 10/2, aempty 1/4
  logic        b_rp_rst, b_wr_en, b_rd_en;
  logic [35:0] b_wr_data, b_rd_data;
  logic        b_full, b_empty, b_afull, b_aempty;
  logic [4:0]  b_data_cnt;
  logic [4:0]  b_af_th = 5'd10, b_af_clr = 5'd2, b_ae_th = 5'd1, b_ae_clr = 5'd4;

  fifo_sc_flags #(.DEPTH(16), .DATA_WIDTH(36), .REGMODE("reg")) dut_a (
    .wr_clk_i              (clk),
    .rst_i                 (rst),
    .rp_rst_i              (a_rp_rst),
    .wr_en_i               (a_wr_en),
    .wr_data_i             (a_wr_data),
    .rd_en_i               (a_rd_en),
    .almost_full_th_i      (a_af_th),
    .almost_full_clr_th_i  (a_af_clr),
    .almost_empty_th_i     (a_ae_th),
    .almost_empty_clr_th_i (a_ae_clr),
    .rd_data_o             (a_rd_data),
    .full_o                (a_full),
    .empty_o               (a_empty),
    .almost_full_o         (a_afull),
    .almost_empty_o        (a_aempty),
    .data_cnt_o            (a_data_cnt)
  );

  fifo_sc_flags #(.DEPTH(12), .DATA_WIDTH(36), .REGMODE("noreg")) dut_b (
    .wr_clk_i              (clk),
    .rst_i                 (rst),
    .rp_rst_i              (b_rp_rst),
    .wr_en_i               (b_wr_en),
    .wr_data_i             (b_wr_data),
    .rd_en_i               (b_rd_en),
    .almost_full_th_i      (b_af_th),
    .almost_full_clr_th_i  (b_af_clr),
    .almost_empty_th_i     (b_ae_th),
    .almost_empty_clr_th_i (b_ae_clr),
    .rd_data_o             (b_rd_data),
    .full_o                (b_full),
    .empty_o               (b_empty),
    .almost_full_o         (b_afull),
    .almost_empty_o        (b_aempty),
    .data_cnt_o            (b_data_cnt)
  );

  function automatic logic [35:0] pat(input int i);
    logic [15:0] s;
    s = i[15:0];
    return {4'h9, s, ~s};
  endfunction

  function automatic logic [4:0] cnt_exp(input int c);
`ifdef FIFO_SC_DATA_CNT_EN
    return 5'(c);
`else
    return 5'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic chk_a(input string tag, input int c, input logic f, input logic e,
                       input logic af, input logic ae);
    chk({tag, ".full"},   a_full,     f);
    chk({tag, ".empty"},  a_empty,    e);
    chk({tag, ".afull"},  a_afull,    af);
    chk({tag, ".aempty"}, a_aempty,   ae);
    chk({tag, ".cnt"},    a_data_cnt, cnt_exp(c));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    rst = 1'b1;
    a_rp_rst = 0; a_wr_en = 0; a_rd_en = 0; a_wr_data = '0;
    b_rp_rst = 0; b_wr_en = 0; b_rd_en = 0; b_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_a("rst_a", 0, 0, 1, 0, 1);
    chk("rst_a.rd_data", a_rd_data, 36'd0);
    chk("rst_b.empty",   b_empty,   1'b1);
    chk("rst_b.aempty",  b_aempty,  1'b1);
    chk("rst_b.rd_data", b_rd_data, 36'd0);
    rst = 1'b0;

    // Fill instance a; hysteresis keeps aempty up through 3..5
    for (int i = 0; i < 16; i++) begin
      a_wr_en = 1; a_wr_data = pat(i);
      step();
      c = i + 1;
      chk_a($sformatf("wr%0d", c), c, c == 16, 0, c >= 8, c < 6);
    end
    a_wr_data = pat(99);
    step();
    chk_a("wr17_ignored", 16, 1, 0, 1, 0);
    a_wr_en = 0;

    // Drain with 2-edge read latency, one rejected read at empty
    for (int k = 1; k <= 18; k++) begin
      a_rd_en = (k <= 17);
      step();
      c = (16 - k > 0) ? 16 - k : 0;
      chk_a($sformatf("rd%0d", k), c, 0, c == 0, c > 3, c <= 2);
      if (k >= 2) chk($sformatf("rd%0d.data", k), a_rd_data, pat((k - 2 < 15) ? k - 2 : 15));
    end
    a_rd_en = 0;

    // Simultaneous write and read at empty, then at full
    a_wr_en = 1; a_rd_en = 1; a_wr_data = pat(100);
    step();
    a_rd_en = 0;
    chk_a("both_at_empty", 1, 0, 0, 0, 1);
    for (int i = 1; i < 16; i++) begin
      a_wr_data = pat(100 + i);
      step();
    end
    chk_a("refill", 16, 1, 0, 1, 0);
    a_rd_en = 1; a_wr_data = pat(999);
    step();
    a_wr_en = 0; a_rd_en = 0;
    chk_a("both_at_full", 15, 0, 0, 1, 0);
    step();
    step();
    chk("both_at_full.data", a_rd_data, pat(100));

    // Flush at 15, refill to 5, flush again with a write pending
    a_rp_rst = 1;
    step();
    a_rp_rst = 0;
    chk_a("flush15", 0, 0, 1, 0, 1);
    a_wr_en = 1;
    for (int i = 0; i < 5; i++) begin
      a_wr_data = pat(200 + i);
      step();
    end
    chk_a("w5", 5, 0, 0, 0, 1);
    a_wr_data = pat(77); a_rp_rst = 1;
    step();
    a_rp_rst = 0; a_wr_en = 0;
    chk_a("flush5", 0, 0, 1, 0, 1);
    chk("flush5.hold", a_rd_data, pat(100));
    a_wr_en = 1; a_wr_data = pat(300);
    step();
    a_wr_en = 0;
    chk_a("post_flush_wr", 1, 0, 0, 0, 1);
    a_rd_en = 1;
    step();
    a_rd_en = 0;
    step();
    chk("post_flush.data", a_rd_data, pat(300));

    // Instance b: write 12, read 6, write 6 across the 11->0 wrap, read 12
    b_wr_en = 1;
    for (int i = 0; i < 12; i++) begin
      b_wr_data = pat(500 + i);
      step();
      chk($sformatf("b_wr%0d.full", i + 1), b_full, i == 11);
    end
    b_wr_en = 0;
    chk("b_fill.afull",  b_afull,    1'b1);
    chk("b_fill.aempty", b_aempty,   1'b0);
    chk("b_fill.cnt",    b_data_cnt, cnt_exp(12));
    b_rd_en = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("b_rd%0d.data", k), b_rd_data, pat(500 + k));
    end
    b_rd_en = 0;
    b_wr_en = 1;
    for (int i = 0; i < 6; i++) begin
      b_wr_data = pat(512 + i);
      step();
    end
    b_wr_en = 0;
    chk("b_wrap.full",  b_full,  1'b1);
    chk("b_wrap.empty", b_empty, 1'b0);
    b_rd_en = 1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("b_rd%0d.data", k + 6), b_rd_data, pat(506 + k));
    end
    b_rd_en = 0;
    chk("b_drain.empty",  b_empty,  1'b1);
    chk("b_drain.afull",  b_afull,  1'b0);
    chk("b_drain.aempty", b_aempty, 1'b1);
    step();
    chk("b_hold.data", b_rd_data, pat(517));

    // Asynchronous reset in the middle of a write burst on a
    a_wr_en = 1; a_wr_data = pat(400);
    step();
    step();
    #3;
    rst = 1'b1;
    #1;
    chk_a("async_rst", 0, 0, 1, 0, 1);
    chk("async_rst.a_data", a_rd_data, 36'd0);
    chk("async_rst.b_data", b_rd_data, 36'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_wr_data = pat(401);
    step();
    a_wr_en = 0;
    chk_a("first_edge_wr", 1, 0, 0, 0, 1);
    a_rd_en = 1;
    step();
    a_rd_en = 0;
    step();
    chk("first_edge.data", a_rd_data, pat(401));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
